vec_operand_stage: RTL and testbench
====================================

Name: vec_operand_stage

Overview:
- Issue/operand-fetch stage directly upstream of the int16x4 vector execute unit.
- Owns the 64-bit vector register file and a per-register busy scoreboard; accepts decoded instructions over a valid/ready handshake.
- Reads both source operands with writeback bypass, stalls on RAW/WAW hazards, and presents opcode + operands + destination to execute through a registered valid/ready output.
- Writeback from downstream returns on a dedicated write port.

Parameters:
- NREGS, 16, number of vector registers (power of two)
- RIDX_W, 4, register index width, equals log2(NREGS)
- DATA_W, 64, register width: four packed signed 16-bit lanes, lane0 in bits [15:0]

Ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts instruction this cycle
- in_opcode  input  4  4'h0 VADD, 4'h1 VSUB, 4'h4 RELU; others pass through (execute yields 0)
- in_rs_a  input  RIDX_W  source A index
- in_rs_b  input  RIDX_W  source B index
- in_rd  input  RIDX_W  destination index
- out_valid  output  1  operands valid to execute
- out_ready  input  1  execute accepts
- out_opcode  output  4  registered opcode
- out_a  output  DATA_W  operand A
- out_b  output  DATA_W  operand B
- out_rd  output  RIDX_W  destination carried to writeback
- wb_en  input  1  writeback strobe
- wb_rd  input  RIDX_W  writeback destination
- wb_data  input  DATA_W  writeback value

Behaviour:
- Reset: all registers 0, busy all 0, out_valid 0, out_opcode/out_a/out_b/out_rd 0. Reset mid-handshake discards the held instruction; busy bits do not survive reset.
- Accept = in_valid && in_ready. Latency: accepted at edge N, out_valid high after edge N (one cycle).
- Output register holds: once out_valid=1, out_* stay stable until out_valid && out_ready.
- in_ready = (!out_valid || out_ready) && !hazard; no combinational path from in_valid to in_ready.
- wb_hit(r) = wb_en && wb_rd==r.
- hazard = RAW_A || RAW_B || WAW:
  - RAW_A = busy[rs_a] && !wb_hit(rs_a)
  - RAW_B = busy[rs_b] && !wb_hit(rs_b) && opcode!=4'h4; RELU ignores B
  - WAW = busy[rd] && !wb_hit(rd)
- Operand read at accept: value = wb_hit(rs) ? wb_data : rf[rs], for A and B independently. rs_a==rs_b is legal.
- Register file write: on wb_en, rf[wb_rd] <= wb_data at the edge.
- Scoreboard:
  - On wb_en, busy[wb_rd] <= 0.
  - On accept, busy[in_rd] <= 1, for every opcode including unknown.
  - Same register set and cleared in one cycle: set wins.
- Source equals own destination (rs_a==rd) is not a hazard unless that register is already busy.
- Back-to-back issue with out_ready=1 and no hazard sustains one instruction per cycle.
- wb_en for a non-busy register: write still performed; busy stays 0.

Decomposition:
- Shared package vec_pkg: opcode constants OP_VADD=4'h0, OP_VSUB=4'h1, OP_RELU=4'h4; DATA_W, lane width 16, lane count 4, RIDX_W.
- One sub-module: vec_regfile, NREGS x DATA_W, one write port, two combinational read ports, async-reset clear. Bypass and scoreboard stay in the top level.

Test Plan:
- Reset, then wb_en rd=2 data=64'h0004_0003_0002_0001; issue VADD rs_a=2 rs_b=2 rd=5 -> next cycle out_valid=1, out_a=out_b=64'h0004_0003_0002_0001, out_rd=5, busy[5]=1.
- Issue VADD rd=5, then VSUB rs_a=5 -> in_ready=0 until wb_en rd=5 data=64'h0008_0006_0004_0002. In that cycle in_ready=1 and out_a=64'h0008_0006_0004_0002 (bypass).
- RELU rs_a=1 rs_b=5 while busy[5]=1 and busy[1]=0 -> accepted without stall; VADD with the same sources stalls.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged and in_ready=0. Raise out_ready -> next queued instruction appears the following cycle.
- Issue rd=7 in the same cycle as wb_en wb_rd=7 -> busy[7]=1 afterwards (set wins); 10 independent instructions with out_ready=1 -> 10 outputs in 10 consecutive cycles.
- Assert reset while out_valid=1 and busy[3]=1 -> out_valid=0 and busy all 0 immediately; rf[3] reads 0 after release.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: shared widths and opcode constants for the int16x4 vector pipeline
package vec_pkg;
  localparam int NREGS = 16;
  localparam int RIDX_W = 4;
  localparam int DATA_W = 64;
  localparam int LANE_W = 16;
  localparam int LANES = 4;
  localparam logic [3:0] OP_VADD = 4'h0;
  localparam logic [3:0] OP_VSUB = 4'h1;
  localparam logic [3:0] OP_RELU = 4'h4;
endpackage

// File: rtl/vec_regfile.sv
// vec_regfile: vector register file, one write port, two combinational read ports
module vec_regfile #(
  parameter int NREGS = vec_pkg::NREGS,
  parameter int RIDX_W = vec_pkg::RIDX_W,
  parameter int DATA_W = vec_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [RIDX_W-1:0] ra_a,
  input  logic [RIDX_W-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);
  logic [DATA_W-1:0] mem [NREGS];
  // write port; reset clears every register
  always_ff @(posedge clk or posedge reset)
    if (reset) mem <= '{default: '0};
    else if (we) mem[wa] <= wd;
  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];
endmodule

// File: rtl/vec_operand_stage.sv
// vec_operand_stage: operand fetch with writeback bypass and busy scoreboard
module vec_operand_stage #(
  parameter int NREGS = vec_pkg::NREGS,
  parameter int RIDX_W = vec_pkg::RIDX_W,
  parameter int DATA_W = vec_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [RIDX_W-1:0] in_rs_a,
  input  logic [RIDX_W-1:0] in_rs_b,
  input  logic [RIDX_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [RIDX_W-1:0] out_rd,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
);
  import vec_pkg::OP_RELU;
  logic [NREGS-1:0] busy, busy_next;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic hit_a, hit_b, hit_d, hazard, accept;
  vec_regfile #(.NREGS(NREGS), .RIDX_W(RIDX_W), .DATA_W(DATA_W)) u_rf (
    .clk(clk), .reset(reset), .we(wb_en), .wa(wb_rd), .wd(wb_data),
    .ra_a(in_rs_a), .ra_b(in_rs_b), .rd_a(rf_a), .rd_b(rf_b)
  );
  assign hit_a = wb_en && wb_rd == in_rs_a;
  assign hit_b = wb_en && wb_rd == in_rs_b;
  assign hit_d = wb_en && wb_rd == in_rd;
  // a same-cycle writeback to a busy register releases the hazard
  assign hazard = (busy[in_rs_a] && !hit_a) ||
                  (busy[in_rs_b] && !hit_b && in_opcode != OP_RELU) ||
                  (busy[in_rd] && !hit_d);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept = in_valid && in_ready;
  // writeback clears first so a same-cycle issue to that register keeps it busy
  always_comb begin
    busy_next = busy;
    if (wb_en) busy_next[wb_rd] = 1'b0;
    if (accept) busy_next[in_rd] = 1'b1;
  end
  // busy scoreboard register
  always_ff @(posedge clk or posedge reset)
    if (reset) busy <= '0;
    else busy <= busy_next;
  // output holding register toward execute
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      out_opcode <= '0;
      out_a <= '0;
      out_b <= '0;
      out_rd <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_opcode <= in_opcode;
      out_a <= hit_a ? wb_data : rf_a;
      out_b <= hit_b ? wb_data : rf_b;
      out_rd <= in_rd;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_vec_operand_stage.sv
// tb_vec_operand_stage: scoreboard bench for the operand stage
module tb_vec_operand_stage;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, wb_en = 0;
  logic [3:0] in_opcode = 0, in_rs_a = 0, in_rs_b = 0, in_rd = 0, wb_rd = 0, out_opcode, out_rd;
  logic [63:0] out_a, out_b, wb_data = 0;
  typedef struct packed {logic [3:0] op; logic [63:0] a; logic [63:0] b; logic [3:0] rd;} exp_t;
  exp_t q[$];
  logic [63:0] rf_m [16];
  logic [15:0] busy_m = 0;
  int vectors = 0, miscompares = 0;
  vec_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drv(logic v, logic [3:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] d);
    in_valid = v; in_opcode = op; in_rs_a = a; in_rs_b = b; in_rd = d;
  endtask
  task automatic wb(logic en, logic [3:0] r, logic [63:0] d);
    wb_en = en; wb_rd = r; wb_data = d;
  endtask
  task automatic model_clear;
    q.delete();
    busy_m = 0;
    for (int i = 0; i < 16; i++) rf_m[i] = 0;
  endtask
  task automatic step;
    logic hz, rdy;
    exp_t e;
    @(negedge clk);
    hz = (busy_m[in_rs_a] && !(wb_en && wb_rd == in_rs_a)) ||
         (busy_m[in_rs_b] && !(wb_en && wb_rd == in_rs_b) && in_opcode != 4'h4) ||
         (busy_m[in_rd] && !(wb_en && wb_rd == in_rd));
    rdy = (q.size() == 0 || out_ready) && !hz;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0 && out_valid) begin
      chk("out_opcode", {60'd0, out_opcode}, {60'd0, q[0].op});
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
      chk("out_rd", {60'd0, out_rd}, {60'd0, q[0].rd});
      if (out_ready) void'(q.pop_front());
    end
    if (in_valid && rdy) begin
      e.op = in_opcode;
      e.a = (wb_en && wb_rd == in_rs_a) ? wb_data : rf_m[in_rs_a];
      e.b = (wb_en && wb_rd == in_rs_b) ? wb_data : rf_m[in_rs_b];
      e.rd = in_rd;
      q.push_back(e);
    end
    if (wb_en) begin
      rf_m[wb_rd] = wb_data;
      busy_m[wb_rd] = 1'b0;
    end
    if (in_valid && rdy) busy_m[in_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_a", out_a, 64'd0);
    chk("rst_out_b", out_b, 64'd0);
    chk("rst_out_rd", {60'd0, out_rd}, 64'd0);
    chk("rst_out_opcode", {60'd0, out_opcode}, 64'd0);
    reset = 0;
    wb(1, 2, 64'h0004_0003_0002_0001); step(); wb(0, 0, 0);
    drv(1, 4'h0, 2, 2, 5); step();
    drv(1, 4'h1, 5, 0, 6); step(); step();
    wb(1, 5, 64'h0008_0006_0004_0002); step(); wb(0, 0, 0);
    drv(1, 4'h4, 1, 6, 8); step();
    drv(1, 4'h0, 1, 6, 9); step(); step();
    wb(1, 6, 64'h1111_2222_3333_4444); step(); wb(0, 0, 0);
    out_ready = 0;
    drv(1, 4'h1, 2, 2, 10); step(); step(); step();
    out_ready = 1; step(); drv(0, 0, 0, 0, 0); step();
    drv(1, 4'h0, 0, 0, 7); wb(1, 7, 64'h7777_0000_7777_0000); step(); wb(0, 0, 0);
    drv(1, 4'h0, 7, 0, 11); step(); step();
    wb(1, 7, 64'hfff9_0007_fff9_0007); step(); wb(0, 0, 0); drv(0, 0, 0, 0, 0); step();
    for (int r = 0; r < 16; r++) begin
      wb(1, 4'(r), {$urandom, $urandom}); step();
    end
    wb(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drv(1, (i % 2) ? 4'h1 : 4'h0, 4'(10 + i % 6), 4'(15 - i % 6), 4'(i)); step();
    end
    drv(0, 0, 0, 0, 0); step();
    for (int i = 0; i < 80; i++) begin
      drv($urandom_range(0, 1), (i % 4 == 3) ? 4'h7 : 4'((i % 3) * 2 == 4 ? 4 : i % 2),
          4'($urandom), 4'($urandom), 4'($urandom));
      wb($urandom_range(0, 1), 4'($urandom), {$urandom, $urandom});
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drv(0, 0, 0, 0, 0); out_ready = 1;
    for (int r = 0; r < 16; r++) begin
      wb(1, 4'(r), 64'(r) * 64'h0101_0101_0101_0101); step();
    end
    wb(0, 0, 0);
    out_ready = 0; drv(1, 4'h0, 1, 2, 3); step(); drv(0, 0, 0, 0, 0); step();
    reset = 1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_a", out_a, 64'd0);
    model_clear();
    @(posedge clk); #1; reset = 0; out_ready = 1;
    drv(1, 4'h0, 3, 3, 4); step(); drv(0, 0, 0, 0, 0); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
